// File: rtl/ftrace_pkg.sv
// Shared decode constants and the trace record layout used by the commit collector.
package ftrace_pkg;

    localparam logic [6:0] OPC_JAL  = 7'b1101111;
    localparam logic [6:0] OPC_JALR = 7'b1100111;

    localparam logic [4:0] REG_RA = 5'd1;
    localparam logic [4:0] REG_T0 = 5'd5;

    localparam int unsigned FT_XLEN = 32;

    typedef struct packed {
        logic [FT_XLEN-1:0] pc;
        logic [FT_XLEN-1:0] nextpc;
        logic               is_jal;
        logic               is_ret;
        logic               is_rd0;
    } ftrace_rec_t;

endpackage

// File: rtl/ftrace_fifo.sv
// Small synchronous FIFO of trace records; a pop in the same cycle frees room for a push when full.
module ftrace_fifo
    import ftrace_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter type         rec_t = ftrace_rec_t
) (
    input  logic clock,
    input  logic reset,
    input  logic push,
    input  rec_t wdata,
    input  logic pop,
    output rec_t rdata,
    output logic full,
    output logic empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr_q, rd_ptr_q;
    rec_t        mem_q [DEPTH];
    logic        do_pop, do_push;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + {{AW{1'b0}}, 1'b1};
            if (do_pop)  rd_ptr_q <= rd_ptr_q + {{AW{1'b0}}, 1'b1};
        end
    end

    // Storage needs no reset: reads are masked while empty.
    always_ff @(posedge clock) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
    end

    assign rdata = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/ftrace_commit_collect.sv
// Filters retired jal/jalr, classifies call/return/jump, queues records for the DPI stage
// and tracks call depth and dropped records.
module ftrace_commit_collect
    import ftrace_pkg::*;
#(
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned XLEN      = 32,
    parameter int unsigned DEPTH_MAX = 255
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            commit_valid,
    input  logic [XLEN-1:0] commit_pc,
    input  logic [31:0]     commit_inst,
    input  logic [XLEN-1:0] commit_nextpc,
    input  logic            out_ready,
    output logic            dpi_valid,
    output logic            func_flag,
    output logic            is_jal,
    output logic            is_ret,
    output logic            is_rd0,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] nextpc,
    output logic [7:0]      call_depth,
    output logic [15:0]     drop_cnt,
    output logic            overflow
);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] nextpc;
        logic            is_jal;
        logic            is_ret;
        logic            is_rd0;
    } rec_t;

    logic [6:0]  opcode;
    logic [4:0]  rd, rs1;
    logic [11:0] imm12;
    logic        dec_jal, dec_jalr, dec_ret, dec_call, dec_rd0;
    logic        push, pop, fifo_full, fifo_empty, drop;
    rec_t        wr_rec, head_rec;
    logic [7:0]  call_depth_q, call_depth_d;
    logic [15:0] drop_cnt_q;
    logic        overflow_q;
    logic        unused_funct3;

    assign opcode        = commit_inst[6:0];
    assign rd            = commit_inst[11:7];
    assign rs1           = commit_inst[19:15];
    assign imm12         = commit_inst[31:20];
    assign unused_funct3 = ^commit_inst[14:12];

    assign dec_jal  = (opcode == OPC_JAL);
    assign dec_jalr = (opcode == OPC_JALR);
    assign dec_rd0  = (rd == 5'd0);
    assign dec_ret  = dec_jalr && dec_rd0 && (rs1 == REG_RA) && (imm12 == 12'd0);
    assign dec_call = (dec_jal || dec_jalr) && ((rd == REG_RA) || (rd == REG_T0));

    assign push = commit_valid && (dec_jal || dec_jalr);
    assign pop  = dpi_valid && out_ready;
    // A same-cycle pop makes room, so only a stalled full queue loses the record.
    assign drop = push && fifo_full && !pop;

    always_comb begin
        wr_rec        = '0;
        wr_rec.pc     = commit_pc;
        wr_rec.nextpc = commit_nextpc;
        wr_rec.is_jal = dec_jal;
        wr_rec.is_ret = dec_ret;
        wr_rec.is_rd0 = dec_rd0;
    end

    ftrace_fifo #(
        .DEPTH (DEPTH),
        .rec_t (rec_t)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .wdata (wr_rec),
        .pop   (pop),
        .rdata (head_rec),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        call_depth_d = call_depth_q;
        if (commit_valid && dec_call && (call_depth_q < 8'(DEPTH_MAX))) begin
            call_depth_d = call_depth_q + 8'd1;
        end else if (commit_valid && dec_ret && (call_depth_q != 8'd0)) begin
            call_depth_d = call_depth_q - 8'd1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            call_depth_q <= '0;
            drop_cnt_q   <= '0;
            overflow_q   <= 1'b0;
        end else begin
            call_depth_q <= call_depth_d;
            if (drop) begin
                overflow_q <= 1'b1;
                if (drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 16'd1;
            end
        end
    end

    assign dpi_valid  = !fifo_empty;
    assign func_flag  = dpi_valid;
    assign is_jal     = head_rec.is_jal;
    assign is_ret     = head_rec.is_ret;
    assign is_rd0     = head_rec.is_rd0;
    assign pc         = head_rec.pc;
    assign nextpc     = head_rec.nextpc;
    assign call_depth = call_depth_q;
    assign drop_cnt   = drop_cnt_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_ftrace_commit_collect.sv
// Randomized and directed bench for ftrace_commit_collect against a queue-based reference model.
module tb_ftrace_commit_collect;

    localparam int unsigned DEPTH = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic        commit_valid;
    logic [31:0] commit_pc, commit_inst, commit_nextpc;
    logic        out_ready;
    logic        dpi_valid, func_flag, is_jal, is_ret, is_rd0, overflow;
    logic [31:0] pc, nextpc;
    logic [7:0]  call_depth;
    logic [15:0] drop_cnt;

    always #5 clock = ~clock;

    ftrace_commit_collect dut (
        .clock         (clock),
        .reset         (reset),
        .commit_valid  (commit_valid),
        .commit_pc     (commit_pc),
        .commit_inst   (commit_inst),
        .commit_nextpc (commit_nextpc),
        .out_ready     (out_ready),
        .dpi_valid     (dpi_valid),
        .func_flag     (func_flag),
        .is_jal        (is_jal),
        .is_ret        (is_ret),
        .is_rd0        (is_rd0),
        .pc            (pc),
        .nextpc        (nextpc),
        .call_depth    (call_depth),
        .drop_cnt      (drop_cnt),
        .overflow      (overflow)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] nextpc;
        logic        jal;
        logic        ret;
        logic        rd0;
    } mrec_t;

    mrec_t q[$];
    int    m_depth;
    int    m_drops;
    bit    m_ovf;
    int    n_cmp = 0;
    int    n_bad = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_clear();
        q.delete();
        m_depth = 0;
        m_drops = 0;
        m_ovf   = 0;
    endtask

    task automatic compare_outputs();
        mrec_t h;
        bit    v;
        v = (q.size() != 0);
        h = '{32'd0, 32'd0, 1'b0, 1'b0, 1'b0};
        if (v) h = q[0];
        check("dpi_valid",  64'(dpi_valid),  64'(v));
        check("func_flag",  64'(func_flag),  64'(v));
        check("is_jal",     64'(is_jal),     64'(h.jal));
        check("is_ret",     64'(is_ret),     64'(h.ret));
        check("is_rd0",     64'(is_rd0),     64'(h.rd0));
        check("pc",         64'(pc),         64'(h.pc));
        check("nextpc",     64'(nextpc),     64'(h.nextpc));
        check("call_depth", 64'(call_depth), 64'(m_depth));
        check("drop_cnt",   64'(drop_cnt),   64'(m_drops));
        check("overflow",   64'(overflow),   64'(m_ovf));
    endtask

    // Reference behaviour for one clock edge, from the classification rules.
    task automatic model_update(input bit v, input logic [31:0] p, input logic [31:0] inst,
                                input logic [31:0] np, input bit rdy);
        logic [6:0] opc;
        logic [4:0] rd, rs1;
        bit         j, jr, is_r, is_c, popped;
        mrec_t      r;
        opc  = inst[6:0];
        rd   = inst[11:7];
        rs1  = inst[19:15];
        j    = (opc == 7'h6F);
        jr   = (opc == 7'h67);
        is_r = jr && rd == 0 && rs1 == 1 && inst[31:20] == 0;
        is_c = (j || jr) && (rd == 1 || rd == 5);
        popped = 0;
        if (rdy && q.size() > 0) begin
            void'(q.pop_front());
            popped = 1;
        end
        if (v && (j || jr)) begin
            if (q.size() < DEPTH) begin
                r = '{p, np, j, is_r, rd == 0};
                q.push_back(r);
            end else begin
                m_ovf = 1;
                if (m_drops < 65535) m_drops++;
            end
        end
        if (v && is_c && m_depth < 255) m_depth++;
        else if (v && is_r && m_depth > 0) m_depth--;
        if (popped && q.size() > DEPTH) check("model_occupancy", 64'(q.size()), 64'(DEPTH));
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are checked on the falling edge.
    task automatic step(input bit v, input logic [31:0] p, input logic [31:0] inst,
                        input logic [31:0] np, input bit rdy);
        commit_valid  = v;
        commit_pc     = p;
        commit_inst   = inst;
        commit_nextpc = np;
        out_ready     = rdy;
        @(negedge clock);
        compare_outputs();
        model_update(v, p, inst, np, rdy);
        @(posedge clock);
        #1;
    endtask

    function automatic logic [31:0] rand_inst();
        logic [31:0] r;
        logic [4:0]  rdv;
        r = $urandom;
        case ($urandom_range(0, 7))
            0: return 32'h0000_8067;
            1: return {r[31:12], 5'd1, 7'h6F};
            2: begin
                rdv = r[0] ? 5'd1 : 5'd5;
                return {r[31:15], 3'b000, rdv, 7'h67};
            end
            3: return {r[31:12], 5'd0, 7'h6F};
            4: return {r[31:15], 3'b000, 5'd0, 7'h67};
            5: return {r[31:7], r[0] ? 7'h6F : 7'h67};
            6: return {r[31:7], 7'h13};
            default: return {r[31:7], r[1] ? 7'h63 : 7'h33};
        endcase
    endfunction

    initial begin
        commit_valid  = 0;
        commit_pc     = 0;
        commit_inst   = 0;
        commit_nextpc = 0;
        out_ready     = 1;
        reset         = 0;
        model_clear();
        #3;
        compare_outputs();
        @(posedge clock);
        #1;
        reset = 1;

        // jal x1, then ret, then a second ret at depth 0
        step(1, 32'h8000_0000, 32'h0080_00EF, 32'h8000_0008, 1);
        step(1, 32'h8000_0010, 32'h0000_8067, 32'h8000_0004, 1);
        step(1, 32'h8000_0004, 32'h0000_8067, 32'h8000_0020, 1);
        step(0, 0, 0, 0, 1);
        // Non-jumps produce nothing
        step(1, 32'h8000_0030, 32'h0010_0093, 32'h8000_0034, 1);
        step(1, 32'h8000_0034, 32'h0000_0063, 32'h8000_0034, 1);
        step(0, 0, 0, 0, 1);

        // Five tail jumps with a stalled consumer: the fifth is dropped
        for (int i = 0; i < 5; i++)
            step(1, 32'h9000_0000 + 32'(i * 4), 32'h0000_006F, 32'h9000_0100 + 32'(i), 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        // Full queue, push while popping: accepted, no drop
        step(1, 32'h9000_0040, 32'h0000_006F, 32'h9000_0200, 1);
        for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 1);

        // Depth saturation
        for (int i = 0; i < 258; i++) step(1, 32'hA000_0000, 32'h0000_02EF, 32'hA000_0000, 1);
        step(1, 32'hA000_0000, 32'h0000_8067, 32'hA000_0004, 1);
        step(0, 0, 0, 0, 1);

        // Reset with three queued records
        for (int i = 0; i < 3; i++) step(1, 32'hB000_0000 + 32'(i), 32'h0080_00EF, 32'hB000_1000, 0);
        commit_valid = 0;
        reset        = 0;
        #1;
        model_clear();
        check("rst_dpi_valid",  64'(dpi_valid),  64'd0);
        check("rst_call_depth", 64'(call_depth), 64'd0);
        compare_outputs();
        @(negedge clock);
        reset = 1;
        @(posedge clock);
        #1;
        step(1, 32'hC000_0000, 32'h0080_00EF, 32'hC000_0008, 1);
        step(0, 0, 0, 0, 1);

        // Random traffic
        for (int i = 0; i < 600; i++)
            step($urandom_range(0, 3) != 0, $urandom, rand_inst(), $urandom,
                 $urandom_range(0, 2) != 0);
        for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ftrace_commit_collect.md
Name: ftrace_commit_collect

Overview:
- Sits between the core's commit port and the function-trace DPI stage.
- Decodes each retired instruction and keeps only control transfers: jal, jalr.
- Classifies each as call, return or plain jump, buffers it in a small FIFO, and presents one record per cycle to the DPI stage.
- Tracks architectural call depth and counts records dropped on overflow.

Parameters:
- DEPTH, 4, FIFO entries; power of two, ≥2.
- XLEN, 32, width of pc/nextpc/inst.
- DEPTH_MAX, 255, saturation value of the call-depth counter.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- commit_valid  in  1  one instruction retires this cycle
- commit_pc  in  XLEN  pc of retiring instruction
- commit_inst  in  32  encoding of retiring instruction
- commit_nextpc  in  XLEN  architectural next pc of that instruction
- out_ready  in  1  consumer accepts the head record (tied 1 when the DPI stage is sink)
- dpi_valid  out  1  head record valid
- func_flag  out  1  record is a jal/jalr (equals dpi_valid)
- is_jal  out  1  1 = jal, 0 = jalr
- is_ret  out  1  record classified as return
- is_rd0  out  1  rd field == x0
- pc  out  XLEN  record pc
- nextpc  out  XLEN  record target
- call_depth  out  8  current call depth, saturating
- drop_cnt  out  16  records lost to full FIFO, saturating at 0xFFFF
- overflow  out  1  sticky: set on first drop

Behaviour:
- Reset (reset=0, async): FIFO empty, pointers 0, all outputs 0, call_depth=0, drop_cnt=0, overflow=0.
- Decode (combinational, commit cycle):
  - opcode=inst[6:0], rd=inst[11:7], rs1=inst[19:15], imm12=inst[31:20].
  - jal = opcode 1101111; jalr = opcode 1100111. Any other opcode is ignored entirely.
- Classification:
  - is_rd0 = (rd==0).
  - ret = jalr & rd==0 & rs1==1 & imm12==0.
  - call = (jal|jalr) & (rd==1 | rd==5).
  - A jump with rd==0 that is not ret is a tail jump: is_rd0=1, is_ret=0.
- Push:
  - Occurs on commit_valid & (jal|jalr).
  - Stores {pc, nextpc, is_jal, is_ret, is_rd0} at the write pointer.
- Pop:
  - Occurs on dpi_valid & out_ready; advances the read pointer.
- Output:
  - dpi_valid = !empty. Record fields are driven from the head entry, all zero when empty.
  - Latency: a record pushed in cycle N is visible at the outputs in cycle N+1.
  - No same-cycle bypass.
- Pointers:
  - log2(DEPTH)+1 bits; wrap modulo 2*DEPTH.
  - empty = pointers equal; full = index equal and MSB differs.
- Full FIFO:
  - Full & push & pop same cycle: the push is accepted (the pop frees the slot). No drop.
  - Full & push & no pop: record discarded; drop_cnt += 1 (saturating); overflow ← 1 (sticky until reset).
- Empty FIFO, push & out_ready same cycle: the push is stored, and nothing pops this cycle because dpi_valid=0.
- Call depth:
  - Updated at commit time, independent of FIFO drops.
  - call → +1, saturates at DEPTH_MAX.
  - ret → −1, saturates at 0 (no wrap).
  - An instruction that is both call and ret is impossible under this classification (rd differs).
- Reset asserted mid-operation: contents discarded immediately; dpi_valid falls asynchronously.
- out_ready low holds the head stable (all record outputs constant) until it is accepted.

Decomposition:
- Shared package ftrace_pkg holds:
  - OPC_JAL and OPC_JALR constants;
  - REG_RA=1 and REG_T0=5;
  - the typedef ftrace_rec_t {pc, nextpc, is_jal, is_ret, is_rd0}.
- One sub-module, ftrace_fifo (parameterised DEPTH, payload = ftrace_rec_t), provides push/pop/full/empty.
- Classification, depth counter and drop counter stay in the top module.

Test Plan:
- Commit jal x1 (inst 0x008000EF) at pc 0x80000000 → nextpc 0x80000008.
  - Next cycle: dpi_valid=1, is_jal=1, is_ret=0, is_rd0=0, pc/nextpc match.
  - call_depth=1.
- Commit ret (0x00008067) at pc 0x80000010 → nextpc 0x80000004 after one call.
  - Next cycle: is_ret=1, is_rd0=1, is_jal=0.
  - call_depth 1→0.
  - A second ret leaves call_depth at 0.
- Commit addi (0x00100093) and a branch with commit_valid=1 → no record; dpi_valid stays 0; call_depth unchanged.
- out_ready=0, commit 5 consecutive jal x0 (0x0000006F):
  - 4 records buffered, 5th dropped; drop_cnt=1, overflow=1.
  - Raise out_ready: the 4 records drain in order over 4 cycles, then dpi_valid=0.
- FIFO full, out_ready=1, push same cycle → occupancy stays 4, drop_cnt unchanged.
- Assert reset low while 3 records are queued → dpi_valid=0 and call_depth=0 immediately. After release, a new jal appears with 1-cycle latency.
